pipe_hazard_ctrl: RTL

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_hazard_ctrl.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/pipe_hazard_ctrl.sv
// ============================================================================
// Module      : pipe_hazard_ctrl
// Description : Forwarding select, load-use / multi-cycle / memory-freeze stall
//               and control-flush generation for a 5-stage in-order pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_hazard_ctrl #(
  parameter int RA_W   = 5,
  parameter int MC_LAT = 4,
  parameter int CNT_W  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [RA_W-1:0]  rs1_ID,
  input  logic [RA_W-1:0]  rs2_ID,
  input  logic             rs1use_ID,
  input  logic             rs2use_ID,
  input  logic             branch_ID,
  input  logic             jal_ID,
  input  logic [RA_W-1:0]  rd_EXE,
  input  logic [RA_W-1:0]  rs2_EXE,
  input  logic             regwrite_EXE,
  input  logic             load_EXE,
  input  logic             store_EXE,
  input  logic             mc_EXE,
  input  logic [RA_W-1:0]  rd_MEM,
  input  logic             regwrite_MEM,
  input  logic             load_MEM,
  input  logic             mem_req_MEM,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             fd_en,
  output logic             fd_flush,
  output logic             de_en,
  output logic             de_flush,
  output logic             em_en,
  output logic             em_flush,
  output logic             mw_en,
  output logic [1:0]       fwd_A,
  output logic [1:0]       fwd_B,
  output logic             fwd_ls,
  output logic             busy,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int              MC_CNT_W = 4;
  localparam logic [MC_CNT_W-1:0] MC_LOAD = MC_CNT_W'(MC_LAT - 2);

  typedef enum logic [0:0] {
    RUN     = 1'b0,
    MC_BUSY = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [MC_CNT_W-1:0] mc_cnt_q, mc_cnt_d;
  logic                mc_done_q, mc_done_d;
  logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;

  logic m1_ex, m2_ex, m1_mem, m2_mem;
  logic lu, mf, ms, mc_trig;

  function automatic logic src_match(input logic [RA_W-1:0] src, input logic use_f,
                                     input logic [RA_W-1:0] rd, input logic rw);
    return use_f & rw & (rd != '0) & (src == rd);
  endfunction

  function automatic logic [1:0] fwd_code(input logic m_ex, input logic m_mem);
    logic [1:0] code;
    code = 2'd0;
    if (m_ex && !load_EXE)        code = 2'd1;
    else if (m_mem && !load_MEM)  code = 2'd2;
    else if (m_mem)               code = 2'd3;
    return code;
  endfunction

  always_comb begin
    m1_ex  = src_match(rs1_ID, rs1use_ID, rd_EXE, regwrite_EXE);
    m2_ex  = src_match(rs2_ID, rs2use_ID, rd_EXE, regwrite_EXE);
    m1_mem = src_match(rs1_ID, rs1use_ID, rd_MEM, regwrite_MEM);
    m2_mem = src_match(rs2_ID, rs2use_ID, rd_MEM, regwrite_MEM);
    fwd_A  = fwd_code(m1_ex, m1_mem);
    fwd_B  = fwd_code(m2_ex, m2_mem);
    fwd_ls = src_match(rs2_EXE, store_EXE, rd_MEM, regwrite_MEM & load_MEM);
    lu     = load_EXE & (m1_ex | m2_ex);
    mf     = mem_req_MEM & ~mem_ready;
  end

  // mc_cnt counts remaining MC_BUSY cycles; a 2-cycle op needs none, so it
  // completes straight from the trigger cycle without entering MC_BUSY.
  always_comb begin
    state_d   = state_q;
    mc_cnt_d  = mc_cnt_q;
    mc_done_d = mc_done_q;
    mc_trig   = 1'b0;
    if (!mf) begin
      case (state_q)
        RUN: begin
          if (mc_EXE && !mc_done_q) begin
            mc_trig = 1'b1;
            if (MC_LOAD == '0) begin
              mc_done_d = 1'b1;
            end else begin
              state_d  = MC_BUSY;
              mc_cnt_d = MC_LOAD;
            end
          end else begin
            mc_done_d = 1'b0;
          end
        end
        MC_BUSY: begin
          mc_cnt_d = mc_cnt_q - 1'b1;
          if (mc_cnt_q <= MC_CNT_W'(1)) begin
            state_d   = RUN;
            mc_done_d = 1'b1;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_comb begin
    ms       = (state_q == MC_BUSY) | mc_trig;
    busy     = mf | ms | lu;
    pc_en    = 1'b0;
    fd_en    = 1'b0;
    fd_flush = 1'b0;
    de_en    = 1'b0;
    de_flush = 1'b0;
    em_en    = 1'b0;
    em_flush = 1'b0;
    mw_en    = 1'b0;
    if (mf) begin
      pc_en = 1'b0;
    end else if (ms) begin
      em_en    = 1'b1;
      em_flush = 1'b1;
      mw_en    = 1'b1;
    end else if (lu) begin
      de_en    = 1'b1;
      de_flush = 1'b1;
      em_en    = 1'b1;
      mw_en    = 1'b1;
    end else begin
      pc_en    = 1'b1;
      fd_en    = 1'b1;
      de_en    = 1'b1;
      em_en    = 1'b1;
      mw_en    = 1'b1;
      fd_flush = branch_ID | jal_ID;
    end
    stall_cnt_d = stall_cnt_q;
    if (busy && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= RUN;
      mc_cnt_q    <= '0;
      mc_done_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      mc_cnt_q    <= mc_cnt_d;
      mc_done_q   <= mc_done_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

`default_nettype wire
